// File: rtl/alu_seg_disp.sv
// alu_seg_disp: eight-digit multiplexed seven-segment hex display driver.
//
// The driver holds a shadow copy of the value to show. A prescaler sets how
// long each digit slot lasts, and a digit index steps through the eight
// digits one slot at a time. Every cycle the anode, segment and decimal
// point outputs are registered from the current index and shadow contents.
//
// Ports
//   clk      in   single clock; all state changes on the rising edge
//   rst      in   asynchronous reset, active high
//   upd      in   load strobe: din/dp_in are captured into the shadow
//                 registers on the edge where upd is high
//   din      in   [31:0] eight hex nibbles; nibble i is shown on digit i
//   dp_in    in   [7:0] decimal point request per digit, 1 = lit
//   blank_lz in   leading-zero blanking enable, sampled live
//   an       out  [7:0] digit anodes, active low, registered
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active low, registered
//   dp       out  decimal point, active low, registered
//   frame    out  one-cycle pulse in the cycle the digit index wraps 7->0
//
// Parameter
//   SCAN_DIV  clk cycles per digit slot (must be >= 2)

module alu_seg_disp #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [31:0] din,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shd_q, shd_d;
  logic [7:0]       shp_q, shp_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic [3:0]       nib;
  logic [31:0]      upper;
  logic             blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    frame_d = tick && (idx_q == 3'd7);
    shd_d   = upd ? din   : shd_q;
    shp_d   = upd ? dp_in : shp_q;
  end

  // Output decode works from the current index and shadow values, so a
  // load or index step shows up on the pins exactly one cycle later.
  always_comb begin
    nib   = shd_q[{idx_q, 2'b00} +: 4];
    // Nibbles idx..7 all zero means this digit is a leading zero.
    upper = shd_q >> {idx_q, 2'b00};
    blank = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);
    an_d  = ~(8'd1 << idx_q);
    seg_d = hex7(nib);
    dp_d  = ~shp_q[idx_q];
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shd_q   <= 32'd0;
      shp_q   <= 8'd0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shd_q   <= shd_d;
      shp_q   <= shp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_alu_seg_disp.sv
// Self-checking bench for alu_seg_disp with SCAN_DIV = 4.
// A cycle-level model derives the digit slot from the number of clock edges
// since reset and checks every output on each falling edge; directed scenarios
// add literal expectations on top of the model.

module tb_alu_seg_disp;

  localparam int SCAN  = 4;
  localparam int FRAME = 8 * SCAN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] din = 32'd0;
  logic [7:0]  dp_in = 8'd0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  alu_seg_disp #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .upd(upd), .din(din), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int          n;       // clock edges since reset release
  logic [31:0] msd;
  logic [7:0]  msp;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_frame;

  function automatic int slot(input int k);
    return (k / SCAN) % 8;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0; msd <= 32'd0; msp <= 8'd0;
      e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0;
    end else begin
      if (blank_lz && slot(n) != 0 && (msd >> (4 * slot(n))) == 32'd0) begin
        e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1;
      end else begin
        e_an  <= ~(8'd1 << slot(n));
        e_seg <= HEX[msd[4*slot(n) +: 4]];
        e_dp  <= ~msp[slot(n)];
      end
      e_frame <= ((n + 1) % FRAME == 0);
      n <= n + 1;
      if (upd) begin
        msd <= din;
        msp <= dp_in;
      end
    end
  end

  always @(negedge clk) begin
    check("model_an", an, e_an);
    check("model_seg", seg, e_seg);
    check("model_dp", dp, e_dp);
    check("model_frame", frame, e_frame);
  end

  // ---------------- directed helpers ----------------
  task automatic wait_an(input logic [7:0] v, input int budget, input string name);
    int k = 0;
    while (an !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, an, v);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] p);
    upd = 1'b1; din = d; dp_in = p;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lit, hit, bad, k;

    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_frame", frame, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("release_an", an, 8'hFE);
    check("release_seg", seg, 7'b1000000);

    // full scan of 01234567
    load(32'h01234567, 8'h00);
    check("d0_seg_7", seg, 7'b1111000);
    for (int i = 0; i < 8; i++) begin
      wait_an(~(8'd1 << i), 3 * SCAN, "scan_order");
      if (i == 7) check("d7_seg_0", seg, 7'b1000000);
    end

    // leading-zero blanking on 000000A5
    blank_lz = 1'b1;
    load(32'h000000A5, 8'h00);
    wait_an(8'hFD, FRAME + 4, "lz_d1");
    check("lz_d1_seg", seg, 7'b0001000);
    wait_an(8'hFE, FRAME + 4, "lz_d0");
    check("lz_d0_seg", seg, 7'b0010010);
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an !== 8'hFF) lit++;
    end
    check("lz_lit_cycles", lit, 2 * SCAN);
    blank_lz = 1'b0;
    @(negedge clk);
    wait_an(8'hFB, FRAME + 4, "nolz_d2");
    check("nolz_d2_seg", seg, 7'b1000000);
    wait_an(8'h7F, FRAME + 4, "nolz_d7");
    check("nolz_d7_seg", seg, 7'b1000000);

    // all zero with blanking: only digit 0 lit
    blank_lz = 1'b1;
    load(32'h0, 8'h00);
    lit = 0; hit = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an !== 8'hFF) lit++;
      if (an === 8'hFE && seg === 7'b1000000) hit++;
    end
    check("zero_lit_cycles", lit, SCAN);
    check("zero_d0_cycles", hit, SCAN);
    blank_lz = 1'b0;

    // frame period and width
    k = 0;
    while (frame !== 1'b1 && k < FRAME + 4) begin @(negedge clk); k++; end
    check("frame_seen", frame, 1'b1);
    check("frame_at_d7", an, 8'h7F);
    @(negedge clk);
    check("frame_width", frame, 1'b0);
    k = 1;
    while (frame !== 1'b1 && k < FRAME + 4) begin @(negedge clk); k++; end
    check("frame_period", k, FRAME);

    // decimal point only on digit 0
    load(32'h0, 8'h01);
    hit = 0; bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (dp === 1'b0) hit++;
      if (dp === 1'b0 && an !== 8'hFE) bad++;
    end
    check("dp_cycles", hit, SCAN);
    check("dp_wrong_digit", bad, 0);

    // upd on the tick that moves the index to digit 3
    load(32'h0, 8'h00);
    k = 0;
    while ((n % FRAME) != 3 * SCAN - 1 && k < FRAME + 4) begin @(negedge clk); k++; end
    check("tick3_found", n % FRAME, 3 * SCAN - 1);
    upd = 1'b1; din = 32'h0000_8000;
    @(negedge clk);
    upd = 1'b0; din = 32'hFFFF_FFFF;
    check("pre_d3_an", an, 8'hFB);
    @(negedge clk);
    check("first_d3_an", an, 8'hF7);
    check("first_d3_seg", seg, 7'b0000000);
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an === 8'hF7 && seg !== 7'b0000000) bad++;
      if (an === 8'hFE && seg !== 7'b1000000) bad++;
    end
    check("no_upd_no_change", bad, 0);

    // reset mid-slot on digit 5
    wait_an(8'hDF, FRAME + 4, "reach_d5");
    #1 rst = 1'b1;
    #1;
    check("async_an", an, 8'hFF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1'b1);
    check("async_frame", frame, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerel_an", an, 8'hFE);
    check("rerel_seg", seg, 7'b1000000);
    k = 1;
    while (an !== 8'hFD && k < 20) begin @(negedge clk); k++; end
    check("restart_d1_edge", k, SCAN + 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
